// File: rtl/clock_rate_controller.sv
// Slow-clock generator: programmable half-period counter driving a 1-cycle tick and a 50% out_clock.
// Rate changes arrive over valid/ready and only take effect at a period boundary, so out_clock never glitches.
module clock_rate_controller #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned DEFAULT_LIMIT = 5000000,
  parameter int unsigned MIN_LIMIT     = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             req_valid_i,
  input  logic [CNT_W-1:0] req_limit_i,
  output logic             req_ready_o,
  output logic             tick_o,
  output logic             out_clock_o,
  output logic [CNT_W-1:0] cur_limit_o,
  output logic             err_limit_o,
  output logic [1:0]       state_o
);

  // state   | meaning
  // IDLE    | stopped, counter and out_clock held at 0, requests applied directly
  // RUN     | counting with cur_limit
  // PEND    | counting, new limit waiting for the next terminal count
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  localparam logic [CNT_W-1:0] LIM_RST = CNT_W'(DEFAULT_LIMIT);
  localparam logic [CNT_W-1:0] LIM_MIN = CNT_W'(MIN_LIMIT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             oc_q, oc_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic xfer, bad, accept, term;

  assign req_ready_o = (state_q != ST_PEND);
  assign xfer        = req_valid_i & req_ready_o;
  assign bad         = (req_limit_i < LIM_MIN);
  assign accept      = xfer & ~bad;
  assign term        = (cnt_q == lim_q - ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    pend_d  = pend_q;
    oc_d    = oc_q;
    tick_d  = 1'b0;
    err_d   = xfer & bad;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        oc_d  = 1'b0;
        if (accept) lim_d = req_limit_i;
        if (run_i) state_d = ST_RUN;
      end
      ST_RUN, ST_PEND: begin
        if (!run_i) begin
          // stopping wins over a coincident terminal count; a pending limit is never dropped
          state_d = ST_IDLE;
          cnt_d   = '0;
          oc_d    = 1'b0;
          if (state_q == ST_PEND) lim_d = pend_q;
          else if (accept)        lim_d = req_limit_i;
        end else begin
          if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            oc_d   = ~oc_q;
            if (state_q == ST_PEND) begin
              lim_d   = pend_q;
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
          if (accept) begin
            pend_d  = req_limit_i;
            state_d = ST_PEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lim_q   <= LIM_RST;
      pend_q  <= '0;
      oc_q    <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      pend_q  <= pend_d;
      oc_q    <= oc_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign tick_o      = tick_q;
  assign out_clock_o = oc_q;
  assign cur_limit_o = lim_q;
  assign err_limit_o = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_clock_rate_controller.sv
// Bench for clock_rate_controller: directed scenarios plus random traffic against a
// cycle-count reference model (elapsed cycles per half-period, queue of pending limits).
module tb_clock_rate_controller;
  localparam int W = 24;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         run = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_limit = '0;
  logic         req_ready, tick, out_clock, err_limit;
  logic [W-1:0] cur_limit;
  logic [1:0]   state;

  clock_rate_controller #(.CNT_W(W), .DEFAULT_LIMIT(4), .MIN_LIMIT(2)) dut (
    .clock_i(clock), .reset_i(reset), .run_i(run), .req_valid_i(req_valid),
    .req_limit_i(req_limit), .req_ready_o(req_ready), .tick_o(tick),
    .out_clock_o(out_clock), .cur_limit_o(cur_limit), .err_limit_o(err_limit),
    .state_o(state)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_log[$];

  // reference model
  bit m_idle;
  int m_cnt;
  int m_lim;
  int m_pend[$];
  bit m_oc, m_tick, m_err;

  function automatic logic [29:0] exp_vec();
    logic [1:0] st;
    st = m_idle ? 2'd0 : ((m_pend.size() != 0) ? 2'd2 : 2'd1);
    return {st, m_tick, m_oc, m_err, (m_pend.size() == 0), W'(m_lim)};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {state, tick, out_clock, err_limit, req_ready, cur_limit};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_cnt = 0; m_lim = 4; m_pend.delete();
    m_oc = 1'b0; m_tick = 1'b0; m_err = 1'b0;
  endtask

  task automatic cycle();
    bit rdy, xf, ok;
    @(posedge clock);
    cyc++;
    rdy = (m_pend.size() == 0);
    xf  = req_valid && rdy;
    ok  = (int'(req_limit) >= 2);
    m_tick = 1'b0;
    m_err  = xf && !ok;
    if (m_idle) begin
      if (xf && ok) m_lim = int'(req_limit);
      if (run) begin m_idle = 1'b0; m_cnt = 0; end
    end else if (!run) begin
      m_idle = 1'b1; m_cnt = 0; m_oc = 1'b0;
      if (m_pend.size() != 0) m_lim = m_pend.pop_front();
      else if (xf && ok)      m_lim = int'(req_limit);
    end else begin
      m_cnt++;
      if (m_cnt == m_lim) begin
        m_cnt = 0; m_tick = 1'b1; m_oc = !m_oc;
        if (m_pend.size() != 0) m_lim = m_pend.pop_front();
      end
      if (xf && ok) m_pend.push_back(int'(req_limit));
    end
    #1;
    if (tick) tick_log.push_back(cyc);
  endtask

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; req_valid = 1'b0; req_limit = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    tick_log.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'd4}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), {2'd0, 4'b0001, 24'd4});
    end
  endtask

  task automatic test_run_basic();
    int start;
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) start = cyc;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL run_basic cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (tick_log.size() != 4) begin
      errors++; $display("FAIL run_basic_tick_count got=%0d exp=4", tick_log.size());
    end else begin
      checks++;
      if (tick_log[0] - start != 4) begin
        errors++; $display("FAIL run_basic_first_tick got=%0d exp=4", tick_log[0] - start);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (tick_log[k] - tick_log[k-1] != 4) begin
          errors++; $display("FAIL run_basic_gap got=%0d exp=4", tick_log[k] - tick_log[k-1]);
        end
      end
    end
  endtask

  task automatic test_rate_change();
    int xc;
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 3) begin req_valid = 1'b1; req_limit = 24'd6; end
      else req_valid = 1'b0;
      cycle();
      if (i == 3) begin
        xc = cyc;
        tick_log.delete();
        checks++;
        if (state !== 2'd2 || req_ready !== 1'b0) begin
          errors++; $display("FAIL rate_change_pending got=%0d/%0b exp=2/0", state, req_ready);
        end
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rate_change cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (tick_log.size() < 3) begin
      errors++; $display("FAIL rate_change_ticks got=%0d exp>=3", tick_log.size());
    end else begin
      checks++;
      if (tick_log[0] - xc != 1 || tick_log[1] - tick_log[0] != 6 || tick_log[2] - tick_log[1] != 6) begin
        errors++; $display("FAIL rate_change_gaps got=%0d,%0d,%0d exp=1,6,6",
                           tick_log[0] - xc, tick_log[1] - tick_log[0], tick_log[2] - tick_log[1]);
      end
    end
    checks++;
    if (req_ready !== 1'b1 || cur_limit !== 24'd6) begin
      errors++; $display("FAIL rate_change_final got=%0b/%0d exp=1/6", req_ready, cur_limit);
    end
  endtask

  task automatic test_reject();
    int pulses = 0;
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i == 2);
      req_limit = 24'd1;
      cycle();
      if (err_limit) pulses++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reject cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || cur_limit !== 24'd4 || state !== 2'd1) begin
      errors++; $display("FAIL reject_summary got=%0d/%0d/%0d exp=1/4/1", pulses, cur_limit, state);
    end
  endtask

  task automatic test_terminal_request();
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 18; i++) begin
      req_valid = (i == 4);
      req_limit = 24'd3;
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL terminal_req cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (tick_log.size() < 4) begin
      errors++; $display("FAIL terminal_req_ticks got=%0d exp>=4", tick_log.size());
    end else begin
      checks++;
      if (tick_log[1] - tick_log[0] != 4 || tick_log[2] - tick_log[1] != 3 || tick_log[3] - tick_log[2] != 3) begin
        errors++; $display("FAIL terminal_req_gaps got=%0d,%0d,%0d exp=4,3,3",
                           tick_log[1] - tick_log[0], tick_log[2] - tick_log[1], tick_log[3] - tick_log[2]);
      end
    end
  endtask

  task automatic test_pending_stop();
    int start = 0;
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = (i == 6);
      req_limit = 24'd5;
      run = (i != 7);
      cycle();
      if (i == 5) begin
        checks++;
        if (out_clock !== 1'b1) begin
          errors++; $display("FAIL pending_stop_pre_oc got=%0b exp=1", out_clock);
        end
      end
      if (i == 7) begin
        checks++;
        if (state !== 2'd0 || out_clock !== 1'b0 || cur_limit !== 24'd5 || tick !== 1'b0) begin
          errors++; $display("FAIL pending_stop_idle got=%0d/%0b/%0d/%0b exp=0/0/5/0",
                             state, out_clock, cur_limit, tick);
        end
        tick_log.delete();
      end
      if (i == 8) start = cyc;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL pending_stop cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (tick_log.size() == 0 || tick_log[0] - start != 5) begin
      errors++; $display("FAIL pending_stop_first_tick got=%0d exp=5",
                         (tick_log.size() == 0) ? -1 : tick_log[0] - start);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    run = 1'b1;
    repeat (6) cycle();
    checks++;
    if (out_clock !== 1'b1) begin
      errors++; $display("FAIL async_reset_pre_oc got=%0b exp=1", out_clock);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, tick, out_clock, err_limit, cur_limit} !== {2'd0, 3'b000, 24'd4}) begin
      errors++; $display("FAIL async_reset_immediate got=%0d/%0b/%0b/%0b/%0d exp=0/0/0/0/4",
                         state, tick, out_clock, err_limit, cur_limit);
    end
    run = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec() || req_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_release got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(0, 19) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_limit = W'($urandom_range(0, 7));
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_rate_change();
    test_reject();
    test_terminal_request();
    test_pending_stop();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
